// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Brief    : Single-byte 8N1 UART transmitter with busy, done and overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] write_data,
  input  logic       write_en,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       overrun_err,
  output logic       uart_tx
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] C_BAUD_MAX = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_busy;
  logic            r_done;
  logic            r_ovr;
  logic            w_bit_end;

  assign w_bit_end   = (r_baud == C_BAUD_MAX);
  assign tx_busy     = r_busy;
  assign tx_done     = r_done;
  assign overrun_err = r_ovr;
  assign uart_tx     = r_tx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Requests during any non-idle state, including the last stop clock, are dropped.
      if (write_en && (r_state != S_IDLE)) begin
        r_ovr <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_baud <= '0;
          if (write_en) begin
            r_shift <= write_data;
            r_state <= S_START;
            r_busy  <= 1'b1;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_byte_tx
// Brief    : Directed self-checking bench for uart_byte_tx (BIT_CYCLES = 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_byte_tx;

  logic       clk;
  logic       reset_n;
  logic [7:0] write_data;
  logic       write_en;
  logic       tx_busy;
  logic       tx_done;
  logic       overrun_err;
  logic       uart_tx;

  int vectors;
  int errors;

  logic       rx_en;
  logic [7:0] rx_q[$];
  logic       rx_stop_q[$];

  uart_byte_tx #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .write_data (write_data),
    .write_en   (write_en),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .overrun_err(overrun_err),
    .uart_tx    (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and let the accepting edge pass.
  task automatic send(input logic [7:0] b);
    write_data = b;
    write_en   = 1'b1;
    step();
    write_en   = 1'b0;
  endtask

  // Walk len cycles of a frame just accepted; optionally inject a request at cycle inj.
  task automatic tx_frame(input logic [7:0] b, input int inj, input int len);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int n = 0; n < len; n++) begin
      write_en   = (n == inj);
      write_data = 8'h00;
      chk("frame_bit", 32'(uart_tx), 32'(bits[n/10]));
      chk("frame_busy", 32'(tx_busy), 32'd1);
      chk("frame_done", 32'(tx_done), 32'd0);
      step();
    end
    write_en = 1'b0;
    if (len == 100) begin
      chk("end_busy", 32'(tx_busy), 32'd0);
      chk("end_done", 32'(tx_done), 32'd1);
      chk("end_line", 32'(uart_tx), 32'd1);
    end
  endtask

  // Reference receiver: samples mid-bit on the falling clock edge.
  initial begin : rx_model
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (rx_en && uart_tx === 1'b0) begin
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          r[i] = uart_tx;
        end
        repeat (10) @(negedge clk);
        rx_q.push_back(r);
        rx_stop_q.push_back(uart_tx);
      end
    end
  end

  initial begin : main
    logic [7:0] pkt [11];
    int         n;
    pkt = '{8'hFF, 8'hFF, 8'h00, 8'h08, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h0D, 8'h0A};
    vectors    = 0;
    errors     = 0;
    rx_en      = 1'b0;
    reset_n    = 1'b0;
    write_en   = 1'b0;
    write_data = 8'h00;

    // Reset held: requests must have no effect.
    for (int i = 0; i < 6; i++) begin
      write_en   = i[0];
      write_data = 8'h55;
      step();
      chk("rst_line", 32'(uart_tx), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_ovr", 32'(overrun_err), 32'd0);
    end
    write_en = 1'b0;

    // Release and request on the first edge after release.
    reset_n = 1'b1;
    send(8'hA5);
    tx_frame(8'hA5, -1, 100);
    step();
    chk("a5_done_once", 32'(tx_done), 32'd0);
    chk("a5_idle_line", 32'(uart_tx), 32'd1);

    // Back-to-back: second request on the tx_done cycle.
    send(8'hFF);
    tx_frame(8'hFF, -1, 100);
    send(8'h0D);
    tx_frame(8'h0D, -1, 100);
    chk("b2b_ovr", 32'(overrun_err), 32'd0);
    step();

    // Reset mid-frame at clock 37.
    send(8'h0A);
    tx_frame(8'h0A, -1, 37);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_line", 32'(uart_tx), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_done", 32'(tx_done), 32'd0);
      chk("mid_rst_line2", 32'(uart_tx), 32'd1);
    end
    reset_n = 1'b1;
    send(8'h5A);
    tx_frame(8'h5A, -1, 100);
    chk("post_rst_ovr", 32'(overrun_err), 32'd0);
    step();

    // Packet stream, each request one clock after tx_busy falls.
    rx_q.delete();
    rx_stop_q.delete();
    rx_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(pkt[i]);
      chk("pkt_busy", 32'(tx_busy), 32'd1);
      n = 0;
      while (tx_busy && n < 200) begin
        step();
        n++;
      end
      chk("pkt_busy_fall", 32'(tx_busy), 32'd0);
      step();
    end
    repeat (20) step();
    rx_en = 1'b0;
    chk("pkt_count", 32'(rx_q.size()), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < rx_q.size()) begin
        chk("pkt_byte", 32'(rx_q[i]), 32'(pkt[i]));
        chk("pkt_stop", 32'(rx_stop_q[i]), 32'd1);
      end
    end
    chk("pkt_ovr", 32'(overrun_err), 32'd0);

    // Overrun: request at clock 45 of a 3C frame.
    send(8'h3C);
    tx_frame(8'h3C, 45, 100);
    chk("ovr_set", 32'(overrun_err), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("ovr_no_frame", 32'(tx_busy), 32'd0);
      chk("ovr_line", 32'(uart_tx), 32'd1);
      chk("ovr_sticky", 32'(overrun_err), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
